// File: rtl/counter_ctrl_pkg.sv
// Shared state encoding and default width for the period-timer controller.
package counter_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_ctrl_core.sv
// WIDTH-bit count register with increment/clear controls and a terminal flag
// that fires one count before the latched limit.
module counter_ctrl_core
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_m1;

  // Modulo-2^WIDTH compare, so a limit of all-ones stops one short of all-ones.
  assign limit_m1 = limit - WIDTH'(1);
  assign terminal = (count_q == limit_m1);
  assign count    = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Period-timer controller: start/pause/resume/clear sequencing around the
// count register, with one-shot or auto-reload expiry pulses.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expire,
  output logic             err
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] period_q;
  logic             reload_q;
  logic             inc;
  logic             clr;
  logic             latch;
  logic             expire_d;
  logic             err_d;
  logic             terminal;

  counter_ctrl_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .inc     (inc),
    .clr     (clr),
    .limit   (period_q),
    .count   (count),
    .terminal(terminal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      reload_q <= 1'b0;
      expire   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      expire  <= expire_d;
      err     <= err_d;
      if (latch) begin
        period_q <= period;
        reload_q <= auto_reload;
      end
    end
  end

  // Priority clear > stop > start; a stop outside RUN is ignored but still
  // masks a simultaneous start.
  always_comb begin
    state_d  = state_q;
    inc      = 1'b0;
    clr      = 1'b0;
    latch    = 1'b0;
    expire_d = 1'b0;
    err_d    = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !stop) begin
            if (period != '0) begin
              latch   = 1'b1;
              clr     = 1'b1;
              state_d = ST_RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (terminal) begin
            clr      = 1'b1;
            expire_d = 1'b1;
            state_d  = reload_q ? ST_RUN : ST_DONE;
          end else begin
            inc = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start && !stop) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, random commands, 8-bit wrap.
`timescale 1ns/1ps
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, clear, auto_reload;
  logic [31:0] period;
  logic [31:0] count;
  logic        busy, done, expire, err;

  logic        start8, stop8, clear8, auto8;
  logic [7:0]  period8;
  logic [7:0]  count8;
  logic        busy8, done8, expire8, err8;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int              m_state;
  longint unsigned m_count, m_period;
  bit              m_reload, m_expire, m_err;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .auto_reload(auto_reload), .period(period), .count(count), .busy(busy),
    .done(done), .expire(expire), .err(err)
  );

  counter_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .stop(stop8), .clear(clear8),
    .auto_reload(auto8), .period(period8), .count(count8), .busy(busy8),
    .done(done8), .expire(expire8), .err(err8)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_count = 0; m_period = 0; m_reload = 0; m_expire = 0; m_err = 0;
  endtask

  // Rules applied to the commands presented at one rising edge.
  task automatic model_step(input bit s, input bit p, input bit c, input bit a, input logic [31:0] per);
    m_expire = 0;
    m_err    = 0;
    if (c) begin
      m_state = M_IDLE;
      m_count = 0;
    end else if (m_state == M_RUN) begin
      if (p) m_state = M_PAUSE;
      else if (m_count + 1 == m_period) begin
        m_count  = 0;
        m_expire = 1;
        if (!m_reload) m_state = M_DONE;
      end else m_count = m_count + 1;
    end else if (!p && s) begin
      if (m_state == M_PAUSE) m_state = M_RUN;
      else if (per != 0) begin
        m_period = per; m_reload = a; m_count = 0; m_state = M_RUN;
      end else m_err = 1;
    end
  endtask

  task automatic cyc(input bit s, input bit p, input bit c, input bit a, input logic [31:0] per);
    @(negedge clk);
    start = s; stop = p; clear = c; auto_reload = a; period = per;
    model_step(s, p, c, a, per);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_count",  count,  m_count[31:0]);
      check("model_busy",   busy,   m_state == M_RUN);
      check("model_done",   done,   m_state == M_DONE);
      check("model_expire", expire, m_expire);
      check("model_err",    err,    m_err);
    end
  end

  initial begin
    reset = 1'b1;
    start = 0; stop = 0; clear = 0; auto_reload = 0; period = 0;
    start8 = 0; stop8 = 0; clear8 = 0; auto8 = 0; period8 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(posedge clk); #2;
    check("post_rst_count", count, 0);
    check("post_rst_flags", {busy, done, expire, err}, 4'b0000);
    chk_en = 1'b1;

    // One-shot, period 5.
    cyc(1, 0, 0, 0, 32'd5);
    check("os_first", {count, busy}, {32'd0, 1'b1});
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      check("os_count", count, i);
    end
    idle(1);
    check("os_wrap", {count, expire, done, busy}, {32'd0, 3'b110});
    idle(1);
    check("os_expire_once", expire, 0);
    idle(19);
    check("os_hold", {count, done}, {32'd0, 1'b1});

    // Auto-reload, period 3, from DONE.
    cyc(1, 0, 0, 1, 32'd3);
    check("ar_first", count, 0);
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      check("ar_count", count, k % 3);
      check("ar_expire", expire, (k % 3) == 0);
      check("ar_done", done, 0);
    end

    // Pause at 4, resume.
    cyc(0, 0, 1, 0, 32'd0);
    cyc(1, 0, 0, 0, 32'd10);
    idle(4);
    check("pz_pre", count, 4);
    cyc(0, 1, 0, 0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("pz_hold", {count, busy}, {32'd4, 1'b0});
    end
    cyc(1, 0, 0, 1, 32'd99);
    check("pz_resume", {count, busy}, {32'd4, 1'b1});
    for (int i = 5; i <= 9; i++) begin
      idle(1);
      check("pz_count", count, i);
    end
    idle(1);
    check("pz_wrap", {count, expire, done}, {32'd0, 2'b11});

    // Stop on the terminal cycle.
    cyc(1, 0, 0, 0, 32'd10);
    idle(9);
    check("term_pre", count, 9);
    cyc(0, 1, 0, 0, 32'd0);
    check("term_stop", {count, expire}, {32'd9, 1'b0});
    idle(2);
    cyc(1, 0, 0, 0, 32'd0);
    check("term_resume", {count, expire, busy}, {32'd9, 2'b01});
    idle(1);
    check("term_wrap", {count, expire, done}, {32'd0, 2'b11});

    // Rejected start and start+clear.
    cyc(0, 0, 1, 0, 32'd0);
    cyc(1, 0, 0, 0, 32'd0);
    check("zero_err", {err, busy, count}, {2'b10, 32'd0});
    idle(1);
    check("zero_err_pulse", err, 0);
    cyc(1, 0, 0, 1, 32'd8);
    idle(3);
    check("sc_pre", count, 3);
    cyc(1, 0, 1, 0, 32'd8);
    check("sc_clear", {count, busy, err, done}, {32'd0, 3'b000});

    // Asynchronous reset mid-RUN at count 7.
    cyc(1, 0, 0, 1, 32'd20);
    idle(7);
    check("ar7_pre", count, 7);
    @(negedge clk);
    #2 reset = 1'b1;
    #0.5;
    check("async_count", count, 0);
    check("async_flags", {busy, done, expire}, 3'b000);
    #0.5 reset = 1'b0;
    model_reset();
    idle(1);
    check("async_idle", {busy, count}, {1'b0, 32'd0});

    // Random commands.
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit s, p, c, a;
      logic [31:0] per;
      r = $urandom_range(0, 99);
      s = 0; p = 0; c = 0;
      if (r < 2) begin c = 1; s = 1; end
      else if (r < 6) c = 1;
      else if (r < 14) p = 1;
      else if (r < 32) s = 1;
      a = $urandom_range(0, 1);
      per = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      cyc(s, p, c, a, per);
    end
    chk_en = 1'b0;

    // 8-bit instance: period all-ones counts up to 254 then wraps.
    @(negedge clk);
    start8 = 1; period8 = 8'hFF; auto8 = 1;
    @(posedge clk); #2;
    check("w8_first", {count8, busy8}, {8'd0, 1'b1});
    @(negedge clk);
    start8 = 0;
    for (int i = 1; i <= 254; i++) begin
      @(posedge clk); #2;
      check("w8_count", {count8, expire8}, {8'(i), 1'b0});
    end
    @(posedge clk); #2;
    check("w8_wrap", {count8, expire8, busy8}, {8'd0, 2'b11});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
